// File: rtl/system_0_pio_out_blink.sv
// Avalon-MM parallel output port with per-bit blink overlay.
// Masked bits of out_port invert every BLINK_PERIOD clocks; reads are combinational.
module system_0_pio_out_blink #(
    parameter int                    DATA_WIDTH     = 18,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                    PRESCALE_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_MASK   = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    logic [DATA_WIDTH-1:0]     data_reg;
    logic [DATA_WIDTH-1:0]     blink_mask;
    logic [PRESCALE_WIDTH-1:0] blink_period;
    logic [PRESCALE_WIDTH-1:0] blink_count;
    logic                      phase;

    logic                      wr_en;
    logic                      restart;
    logic                      terminal;
    logic [DATA_WIDTH-1:0]     wdata_d;
    logic [PRESCALE_WIDTH-1:0] wdata_p;
    logic                      unused_wdata;

    assign wr_en    = chipselect & ~write_n;
    assign restart  = wr_en & ((address == ADDR_PERIOD) | (address == ADDR_STATUS));
    assign terminal = (blink_count == blink_period - PRESCALE_WIDTH'(1));
    assign wdata_d  = writedata[DATA_WIDTH-1:0];
    assign wdata_p  = writedata[PRESCALE_WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg     <= RESET_VALUE;
            blink_mask   <= '0;
            blink_period <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_reg     <= wdata_d;
                ADDR_SET:    data_reg     <= data_reg | wdata_d;
                ADDR_CLEAR:  data_reg     <= data_reg & ~wdata_d;
                ADDR_TOGGLE: data_reg     <= data_reg ^ wdata_d;
                ADDR_MASK:   blink_mask   <= wdata_d;
                ADDR_PERIOD: blink_period <= wdata_p;
                default:     ;
            endcase
        end
    end

    // Restart clears the counter even when the period shrinks, so no long wrap.
    always_ff @(posedge clk) begin
        if (reset || restart || (blink_period == '0)) begin
            blink_count <= '0;
            phase       <= 1'b0;
        end else if (terminal) begin
            blink_count <= '0;
            phase       <= ~phase;
        end else begin
            blink_count <= blink_count + PRESCALE_WIDTH'(1);
        end
    end

    assign out_port = data_reg ^ (blink_mask & {DATA_WIDTH{phase}});

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[DATA_WIDTH-1:0]     = data_reg;
            ADDR_MASK:   readdata[DATA_WIDTH-1:0]     = blink_mask;
            ADDR_PERIOD: readdata[PRESCALE_WIDTH-1:0] = blink_period;
            ADDR_STATUS: readdata[0]                  = phase;
            default:     readdata = '0;
        endcase
    end

endmodule
